// File: rtl/kbd_ps2_pkg.sv
`default_nettype none
// ============================================================================
// kbd_ps2_pkg : shared PS/2 frame constants, FSM encodings and error codes
// Rev 1.0
// ============================================================================
package kbd_ps2_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_INHIBIT   = 3'd1;
    localparam state_t ST_RTS       = 3'd2;
    localparam state_t ST_SEND      = 3'd3;
    localparam state_t ST_ACK       = 3'd4;
    localparam state_t ST_WAIT_IDLE = 3'd5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    localparam int         DATA_BITS   = 8;
    localparam logic [3:0] PARITY_EDGE = 4'd9;
    localparam logic [3:0] STOP_EDGE   = 4'd10;
    localparam logic [3:0] ACK_EDGE    = 4'd11;

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_edge_sync.sv
`default_nettype none
// ============================================================================
// kbd_edge_sync : synchronizer for kbdclk/kbddata plus kbdclk falling-edge detect
// Rev 1.0
// ============================================================================
module kbd_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic kbdclk_i,
    input  logic kbddata_i,
    output logic kbdclk_o,
    output logic kbddata_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;

    // Lines idle high, so reset the chains to 1 to avoid a spurious fall.
    generate
        if (SYNC_STAGES > 1) begin : g_chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    clk_sync_q  <= '1;
                    data_sync_q <= '1;
                end else begin
                    clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], kbdclk_i};
                    data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], kbddata_i};
                end
            end
        end else begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    clk_sync_q  <= '1;
                    data_sync_q <= '1;
                end else begin
                    clk_sync_q  <= kbdclk_i;
                    data_sync_q <= kbddata_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= kbdclk_o;
        end
    end

    assign kbdclk_o  = clk_sync_q[SYNC_STAGES-1];
    assign kbddata_o = data_sync_q[SYNC_STAGES-1];
    assign fall_o    = clk_prev_q & ~kbdclk_o;

endmodule
`default_nettype wire

// File: rtl/kbd_host_tx.sv
`default_nettype none
// ============================================================================
// kbd_host_tx : PS/2 host-to-keyboard command byte transmitter
// Rev 1.0
// ============================================================================
module kbd_host_tx
    import kbd_ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 750000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       kbdclk_in,
    input  logic       kbddata_in,
    output logic       kbdclk_oe,
    output logic       kbddata_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int CNT_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC + 1) : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic                 w_clk_s;
    logic                 w_data_s;
    logic                 w_fall;

    state_t               state_q,    state_d;
    logic [DATA_BITS-1:0] data_q,     data_d;
    logic                 par_q,      par_d;
    logic [3:0]           bitcnt_q,   bitcnt_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [TMO_W-1:0]     tmo_q,      tmo_d;
    logic                 clk_oe_q,   clk_oe_d;
    logic                 data_oe_q,  data_oe_d;
    logic                 done_q,     done_d;
    logic                 err_q,      err_d;
    logic [1:0]           err_code_q, err_code_d;

    logic                 w_tmo_hit;
    logic                 w_do_tmo;
    logic [3:0]           w_next_bit;

    kbd_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .kbdclk_i  (kbdclk_in),
        .kbddata_i (kbddata_in),
        .kbdclk_o  (w_clk_s),
        .kbddata_o (w_data_s),
        .fall_o    (w_fall)
    );

    assign w_tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign w_next_bit = bitcnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        par_d      = par_q;
        bitcnt_d   = bitcnt_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        w_do_tmo   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    data_d     = tx_data;
                    par_d      = odd_parity(tx_data);
                    err_code_d = ERR_NONE;
                    cnt_d      = '0;
                    clk_oe_d   = 1'b1;
                    state_d    = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = ST_RTS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RTS: begin
                // Start bit stays driven low; the device now owns the clock.
                clk_oe_d = 1'b0;
                tmo_d    = '0;
                bitcnt_d = '0;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (w_tmo_hit) begin
                    w_do_tmo = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (w_fall) begin
                        bitcnt_d = w_next_bit;
                        if (w_next_bit == PARITY_EDGE) begin
                            data_oe_d = ~par_q;
                        end else if (w_next_bit == STOP_EDGE) begin
                            data_oe_d = 1'b0;
                            state_d   = ST_ACK;
                        end else begin
                            data_oe_d = ~data_q[bitcnt_q[2:0]];
                        end
                    end
                end
            end
            ST_ACK: begin
                if (w_fall) begin
                    bitcnt_d = ACK_EDGE;
                    cnt_d    = '0;
                    state_d  = ST_WAIT_IDLE;
                    if (!w_data_s) begin
                        done_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NOACK;
                    end
                end else if (w_tmo_hit) begin
                    w_do_tmo = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (w_clk_s && w_data_s) begin
                    if (cnt_q != '0) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        if (w_do_tmo) begin
            clk_oe_d   = 1'b0;
            data_oe_d  = 1'b0;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            cnt_d      = '0;
            state_d    = ST_WAIT_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            par_q      <= 1'b0;
            bitcnt_q   <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            par_q      <= par_d;
            bitcnt_q   <= bitcnt_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign tx_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign kbdclk_oe  = clk_oe_q;
    assign kbddata_oe = data_oe_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_kbd_host_tx.sv
`default_nettype none
// ============================================================================
// tb_kbd_host_tx : PS/2 device model and frame-level checker for kbd_host_tx
// Rev 1.0
// ============================================================================
module tb_kbd_host_tx;

    localparam int INH = 20;
    localparam int TMO = 400;

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       kbdclk_oe;
    logic       kbddata_oe;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic       dev_clk;
    logic       dev_data;
    logic       kbdclk_line;
    logic       kbddata_line;

    // Open-drain wired-AND of host and device drivers.
    assign kbdclk_line  = dev_clk  & ~kbdclk_oe;
    assign kbddata_line = dev_data & ~kbddata_oe;

    kbd_host_tx #(
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TMO),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .kbdclk_in  (kbdclk_line),
        .kbddata_in (kbddata_line),
        .kbdclk_oe  (kbdclk_oe),
        .kbddata_oe (kbddata_oe),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0, acc_cyc = 0;
    int first_oe_cyc = 0, inh_run = 0, rts_run = 0, inh_len = 0, rts_len = 0, rel_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            cyc++;
            chk("done_err_overlap", {31'd0, done & err}, 32'd0);
            chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~tx_ready});
            if (!busy) chk("idle_lines", {30'd0, kbdclk_oe, kbddata_oe}, 32'd0);
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
                chk("err_lines", {30'd0, kbdclk_oe, kbddata_oe}, 32'd0);
            end
            if (tx_valid && tx_ready) acc_cyc = cyc;
            if (kbdclk_oe && !kbddata_oe) begin
                if (inh_run == 0) first_oe_cyc = cyc;
                inh_run++;
            end else if (kbdclk_oe && kbddata_oe) begin
                if (rts_run == 0) inh_len = inh_run;
                rts_run++;
            end else begin
                if (rts_run != 0) begin
                    rts_len = rts_run;
                    rel_cyc = cyc;
                end
                inh_run = 0;
                rts_run = 0;
            end
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!tx_ready && n < 1000) begin
            tick(1);
            n++;
        end
        chk(nm, {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic do_send(input logic [7:0] b);
        wait_ready("ready_before_send");
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Device: waits for request-to-send, clocks 11 falls, samples data at the end of each low
    // phase, and answers edge 11 with ACK (data low) or leaves data high.
    task automatic device(input bit ack, input int stop_fall, output logic [9:0] bits, output bit ok);
        int n = 0;
        bits = '0;
        ok   = 1'b0;
        while (!(kbdclk_line === 1'b1 && kbddata_line === 1'b0) && n < INH + 50) begin
            tick(1);
            n++;
        end
        if (n >= INH + 50) return;
        ok = 1'b1;
        tick($urandom_range(3, 10));
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            tick($urandom_range(6, 10));
            if (k <= 10) bits[k-1] = kbddata_line;
            if (k == stop_fall) return;
            dev_clk = 1'b1;
            if (k == 10) dev_data = ack ? 1'b0 : 1'b1;
            if (k == 11) dev_data = 1'b1;
            tick($urandom_range(6, 10));
        end
    endtask

    task automatic check_frame(input string nm, input logic [7:0] b, input logic [9:0] bits);
        chk({nm, "_data"}, {24'd0, bits[7:0]}, {24'd0, b});
        chk({nm, "_parity"}, {31'd0, bits[8]}, {31'd0, ~^b});
        chk({nm, "_stop"}, {31'd0, bits[9]}, 32'd1);
        chk({nm, "_inhibit_len"}, inh_len, INH);
        chk({nm, "_rts_len"}, rts_len, 1);
        chk({nm, "_latency"}, first_oe_cyc - acc_cyc, 1);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input string nm,
                             output logic [9:0] bits);
        int d0 = done_cnt;
        int e0 = err_cnt;
        bit ok;
        do_send(b);
        device(ack, 0, bits, ok);
        chk({nm, "_rts_seen"}, {31'd0, ok}, 32'd1);
        wait_ready({nm, "_back_idle"});
        check_frame(nm, b, bits);
        chk({nm, "_done_pulses"}, done_cnt - d0, ack ? 1 : 0);
        chk({nm, "_err_pulses"}, err_cnt - e0, ack ? 0 : 1);
        chk({nm, "_err_code"}, {30'd0, err_code}, ack ? 32'd0 : 32'd2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        logic [7:0] b;
        bit         ok;
        int         d0, e0, n;

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        fork
            compare_loop();
        join_none
        tick(3);
        chk("reset_state", {24'd0, tx_ready, busy, kbdclk_oe, kbddata_oe, done, err, err_code},
            32'h80);
        rst = 1'b0;
        tick(2);

        // Known command bytes with hand-computed frames {parity, data}.
        run_frame(8'hED, 1'b1, "ed", bits);
        chk("ed_literal", {23'd0, bits[8:0]}, 32'h1ED);
        run_frame(8'h01, 1'b1, "x01", bits);
        chk("x01_literal", {23'd0, bits[8:0]}, 32'h001);
        run_frame(8'hFF, 1'b1, "xff", bits);
        chk("xff_literal", {23'd0, bits[8:0]}, 32'h1FF);

        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            run_frame(b, 1'b1, "rand", bits);
        end

        // Device never clocks after request-to-send.
        d0 = done_cnt;
        e0 = err_cnt;
        do_send(8'hAA);
        n = 0;
        while (err_cnt == e0 && n < INH + TMO + 100) begin
            tick(1);
            n++;
        end
        chk("tmo_seen", err_cnt - e0, 1);
        chk("tmo_delay", err_cyc - rel_cyc, TMO);
        chk("tmo_code", {30'd0, err_code}, 32'd1);
        chk("tmo_no_done", done_cnt - d0, 0);
        chk("tmo_lines", {30'd0, kbdclk_oe, kbddata_oe}, 32'd0);
        wait_ready("tmo_back_idle");

        // No ACK on edge 11; error code holds until the next accept.
        run_frame(8'h55, 1'b0, "noack", bits);
        tick(5);
        chk("noack_code_held", {30'd0, err_code}, 32'd2);

        // Reset during bit 4.
        d0 = done_cnt;
        e0 = err_cnt;
        do_send(8'h96);
        device(1'b1, 4, bits, ok);
        chk("rst_rts_seen", {31'd0, ok}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_lines", {30'd0, kbdclk_oe, kbddata_oe}, 32'd0);
        chk("rst_mid_ready", {31'd0, tx_ready}, 32'd1);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("rst_ready_after", {31'd0, tx_ready}, 32'd1);
        chk("rst_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        run_frame(8'hF4, 1'b1, "post_rst", bits);

        // tx_valid held with changing tx_data during a transfer.
        d0 = done_cnt;
        wait_ready("hold_ready");
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick(1);
        fork
            begin
                int g = 0;
                while (done_cnt == d0 && g < 2000) begin
                    tx_data = 8'($urandom);
                    tick(1);
                    g++;
                end
                tx_valid = 1'b0;
            end
            device(1'b1, 0, bits, ok);
        join
        chk("hold_rts_seen", {31'd0, ok}, 32'd1);
        wait_ready("hold_back_idle");
        check_frame("hold", 8'h3C, bits);
        chk("hold_done", done_cnt - d0, 1);
        tick(4);
        chk("hold_no_restart", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
